// File: rtl/weight_buffer_sequencer.sv
// weight_buffer_sequencer: owns both weight_buffer ports; loads weights from a
// valid/ready stream and replays contiguous wrap-around read bursts.
module weight_buffer_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_WEIGHTS = 256,
    parameter int ADDR_W      = $clog2(NUM_WEIGHTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_load,
    input  logic [ADDR_W:0]       load_len,
    input  logic                  start_stream,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       stream_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  buf_load_enable,
    output logic [ADDR_W-1:0]     buf_load_addr,
    output logic [DATA_WIDTH-1:0] buf_load_data,
    output logic                  buf_read_enable,
    output logic [ADDR_W-1:0]     buf_read_addr,
    input  logic [DATA_WIDTH-1:0] buf_weight_data,
    output logic                  w_valid,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    state_t                state, state_d;
    logic [ADDR_W-1:0]     wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, read_addr_d;
    logic [ADDR_W:0]       remaining, remaining_d;
    logic                  read_en_d, w_last_d, done_d, err_d, any_start;

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_ONE;
    endfunction

    assign s_ready         = (state == LOAD);
    assign busy            = (state != IDLE);
    assign buf_load_enable = s_valid & s_ready;
    assign buf_load_addr   = wr_ptr;
    assign buf_load_data   = s_data;
    assign w_data          = buf_weight_data;
    assign any_start       = start_load | start_stream;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            remaining       <= '0;
            buf_read_enable <= 1'b0;
            buf_read_addr   <= '0;
            w_valid         <= 1'b0;
            w_last          <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            state           <= state_d;
            wr_ptr          <= wr_ptr_d;
            rd_ptr          <= rd_ptr_d;
            remaining       <= remaining_d;
            buf_read_enable <= read_en_d;
            buf_read_addr   <= read_addr_d;
            w_valid         <= buf_read_enable;
            w_last          <= w_last_d;
            done            <= done_d;
            err             <= err_d;
        end
    end

    // Next-state logic; the first read is issued on the start edge so data
    // appears two cycles after start_stream.
    always_comb begin
        state_d     = state;
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        remaining_d = remaining;
        read_en_d   = 1'b0;
        read_addr_d = buf_read_addr;
        w_last_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state)
            IDLE: begin
                if (start_load) begin
                    err_d = start_stream;
                    if (load_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = LOAD;
                        wr_ptr_d    = '0;
                        remaining_d = load_len;
                    end
                end else if (start_stream) begin
                    if (stream_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = STREAM;
                        read_en_d   = 1'b1;
                        read_addr_d = base_addr;
                        rd_ptr_d    = inc(base_addr);
                        remaining_d = stream_len - LEN_ONE;
                    end
                end
            end
            LOAD: begin
                err_d = any_start;
                if (s_valid) begin
                    wr_ptr_d    = inc(wr_ptr);
                    remaining_d = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            STREAM: begin
                err_d = any_start;
                if (remaining != '0) begin
                    read_en_d   = 1'b1;
                    read_addr_d = rd_ptr;
                    rd_ptr_d    = inc(rd_ptr);
                    remaining_d = remaining - LEN_ONE;
                end else begin
                    state_d  = DRAIN;
                    w_last_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: begin
                err_d   = any_start;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_weight_buffer_sequencer.sv
// tb_weight_buffer_sequencer: directed bench with a behavioural weight_buffer.
module tb_weight_buffer_sequencer;
    localparam int DW = 8;
    localparam int N  = 256;
    localparam int AW = 8;

    typedef struct {
        int       base;
        int       len;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_load = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          start_stream = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   stream_len = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, buf_load_enable, buf_read_enable, w_valid, w_last, busy, done, err;
    logic [AW-1:0] buf_load_addr, buf_read_addr;
    logic [DW-1:0] buf_load_data, buf_weight_data, w_data;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] exp_mem [N];
    logic          init = 1'b1;
    int            total = 0;
    int            passed = 0;
    vec_t          tbl [5];

    weight_buffer_sequencer #(.DATA_WIDTH(DW), .NUM_WEIGHTS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .load_len(load_len),
        .start_stream(start_stream), .base_addr(base_addr), .stream_len(stream_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .buf_load_enable(buf_load_enable), .buf_load_addr(buf_load_addr),
        .buf_load_data(buf_load_data), .buf_read_enable(buf_read_enable),
        .buf_read_addr(buf_read_addr), .buf_weight_data(buf_weight_data),
        .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural weight_buffer: synchronous write, 1-cycle registered read.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < N; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else begin
            if (buf_load_enable) mem[buf_load_addr] <= buf_load_data;
            if (buf_read_enable) buf_weight_data <= mem[buf_read_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    task automatic feed(input int len, input logic [7:0] first_val);
        for (int i = 0; i < len; i++) begin
            if (i % 3 == 1) begin
                s_valid = 1'b0;
                #1;
                check("gap_ready", 32'(s_ready), 32'd1);
                check("gap_wen", 32'(buf_load_enable), 32'd0);
                check("gap_done", 32'(done), 32'd0);
                step();
            end
            s_valid = 1'b1;
            s_data  = first_val + 8'(i);
            #1;
            check("load_wen", 32'(buf_load_enable), 32'd1);
            check("load_addr", 32'(buf_load_addr), 32'(i));
            check("load_data", 32'(buf_load_data), 32'(first_val + 8'(i)));
            exp_mem[i] = first_val + 8'(i);
            step();
        end
        s_valid = 1'b0;
        #1;
        check("load_ready_drop", 32'(s_ready), 32'd0);
        check("load_done", 32'(done), 32'd1);
        check("load_busy", 32'(busy), 32'd0);
        step();
        check("load_done_once", 32'(done), 32'd0);
    endtask

    task automatic run_stream(input int base, input int len, input logic [7:0] first, input logic [7:0] last);
        int issues = 0;
        int beats = 0;
        logic [7:0] got_first = '0;
        logic [7:0] got_last = '0;
        start_stream = 1'b1;
        base_addr    = AW'(base);
        stream_len   = (AW + 1)'(len);
        step();
        start_stream = 1'b0;
        for (int c = 1; c <= len + 3; c++) begin
            check("st_busy", 32'(busy), 32'(c <= len + 1));
            check("st_done", 32'(done), 32'(w_valid && beats == len - 1));
            if (buf_read_enable) begin
                check("st_raddr", 32'(buf_read_addr), 32'((base + issues) % N));
                issues++;
            end
            if (w_valid) begin
                check("st_wdata", 32'(w_data), 32'(exp_mem[(base + beats) % N]));
                check("st_wlast", 32'(w_last), 32'(beats == len - 1));
                check("st_beat_cycle", 32'(c), 32'(beats + 2));
                if (beats == 0) got_first = w_data;
                got_last = w_data;
                beats++;
            end else begin
                check("st_wlast_idle", 32'(w_last), 32'd0);
            end
            step();
        end
        check("st_issues", 32'(issues), 32'(len));
        check("st_beats", 32'(beats), 32'(len));
        check("st_first", 32'(got_first), 32'(first));
        check("st_last", 32'(got_last), 32'(last));
    endtask

    initial begin
        for (int i = 0; i < N; i++) exp_mem[i] = 8'(i) ^ 8'hA5;
        tbl[0] = '{base: 4,     len: 8,   first: 8'h14, last: 8'h1B};
        tbl[1] = '{base: N - 2, len: 4,   first: 8'h5B, last: 8'h11};
        tbl[2] = '{base: 0,     len: 1,   first: 8'h10, last: 8'h10};
        tbl[3] = '{base: 15,    len: 3,   first: 8'h1F, last: 8'hB4};
        tbl[4] = '{base: 0,     len: 256, first: 8'h10, last: 8'h5A};
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_ren", 32'(buf_read_enable), 32'd0);
        check("rst_raddr", 32'(buf_read_addr), 32'd0);
        check("rst_laddr", 32'(buf_load_addr), 32'd0);
        check("rst_wvalid", 32'(w_valid), 32'd0);
        check("rst_done_err", 32'({done, err, w_last}), 32'd0);
        init = 1'b0;
        rst_n = 1'b1;
        step();
        // Load 16 words with gaps.
        start_load = 1'b1;
        load_len   = 9'd16;
        step();
        start_load = 1'b0;
        check("load_start_busy", 32'(busy), 32'd1);
        feed(16, 8'h10);
        // Stream table.
        for (int t = 0; t < 5; t++) run_stream(tbl[t].base, tbl[t].len, tbl[t].first, tbl[t].last);
        // Simultaneous starts: load wins with an error pulse.
        start_load   = 1'b1;
        start_stream = 1'b1;
        load_len     = 9'd2;
        stream_len   = 9'd4;
        step();
        start_load   = 1'b0;
        start_stream = 1'b0;
        check("both_err", 32'(err), 32'd1);
        check("both_ready", 32'(s_ready), 32'd1);
        check("both_ren", 32'(buf_read_enable), 32'd0);
        step();
        check("both_err_once", 32'(err), 32'd0);
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
        check("busy_err", 32'(err), 32'd1);
        check("busy_still_load", 32'(s_ready), 32'd1);
        check("busy_no_read", 32'(buf_read_enable), 32'd0);
        feed(2, 8'hC0);
        run_stream(0, 2, 8'hC0, 8'hC1);
        // Zero-length operations.
        start_load = 1'b1;
        load_len   = '0;
        step();
        start_load = 1'b0;
        check("zl_done", 32'(done), 32'd1);
        check("zl_busy", 32'(busy), 32'd0);
        check("zl_ready", 32'(s_ready), 32'd0);
        step();
        check("zl_done_once", 32'(done), 32'd0);
        start_stream = 1'b1;
        stream_len   = '0;
        step();
        start_stream = 1'b0;
        check("zs_done", 32'(done), 32'd1);
        check("zs_busy", 32'(busy), 32'd0);
        check("zs_ren", 32'(buf_read_enable), 32'd0);
        step();
        check("zs_wvalid", 32'(w_valid), 32'd0);
        // Reset in the middle of a stream.
        start_stream = 1'b1;
        base_addr    = 8'd0;
        stream_len   = 9'd8;
        step();
        start_stream = 1'b0;
        step();
        step();
        step();
        check("mid_beat3", 32'(w_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_wvalid", 32'(w_valid), 32'd0);
        check("arst_ren", 32'(buf_read_enable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_flags", 32'({w_last, done, err, s_ready}), 32'd0);
        check("arst_raddr", 32'(buf_read_addr), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        run_stream(tbl[0].base, tbl[0].len, tbl[0].first, tbl[0].last);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
